// File: rtl/spoc_perm_sched_if.sv
// Controller/datapath-facing signal bundle of the sLiSCP-light permutation scheduler.
// master = controller/datapath side, slave = scheduler.
interface spoc_perm_sched_if #(
    parameter int NUM_STEPS       = 18,
    parameter int ROUNDS_PER_STEP = 6
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int RW = $clog2(ROUNDS_PER_STEP);

    logic          start;
    logic          stall;
    logic          busy;
    logic          init_perm;
    logic          perm_en;
    logic [SW-1:0] step_cnt;
    logic [RW-1:0] round_cnt;
    logic [5:0]    rc;
    logic [5:0]    sc;
    logic          last_round;
    logic          done;

    modport master (
        output start, stall,
        input  busy, init_perm, perm_en, step_cnt, round_cnt, rc, sc, last_round, done
    );

    modport slave (
        input  start, stall,
        output busy, init_perm, perm_en, step_cnt, round_cnt, rc, sc, last_round, done
    );
endinterface

// File: rtl/spoc_perm_sched.sv
// Round/step sequencer for the sLiSCP-light permutation: drives the datapath round enable,
// round/step indices and the LFSR-generated round/step constants, then pulses done.
module spoc_perm_sched #(
    parameter int         NUM_STEPS       = 18,
    parameter int         ROUNDS_PER_STEP = 6,
    parameter logic [5:0] RC_SEED         = 6'h07,
    parameter logic [5:0] SC_SEED         = 6'h2A
) (
    input  logic               clk,
    input  logic               rst,
    spoc_perm_sched_if.slave   bus
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int RW = $clog2(ROUNDS_PER_STEP);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] step_q;
    logic [RW-1:0] round_q;
    logic [5:0]    rc_q, sc_q;
    logic          step_end, perm_last, adv;
    logic          busy, init_perm, done;

    // x^6 + x^5 + 1, period 63
    function automatic logic [5:0] lfsr6(input logic [5:0] q);
        return {q[4:0], q[5] ^ q[4]};
    endfunction

    assign adv       = (state == RUN) && !bus.stall;
    assign step_end  = (round_q == RW'(ROUNDS_PER_STEP - 1));
    assign perm_last = adv && step_end && (step_q == SW'(NUM_STEPS - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        init_perm = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                init_perm = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (perm_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step_q  <= '0;
            round_q <= '0;
            rc_q    <= RC_SEED;
            sc_q    <= SC_SEED;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                step_q  <= '0;
                round_q <= '0;
                rc_q    <= RC_SEED;
                sc_q    <= SC_SEED;
            end else if (adv) begin
                rc_q <= lfsr6(rc_q);
                // final round leaves the indices at their maximum so DONE shows them
                if (!perm_last) begin
                    if (step_end) begin
                        round_q <= '0;
                        step_q  <= step_q + SW'(1);
                        sc_q    <= lfsr6(sc_q);
                    end else begin
                        round_q <= round_q + RW'(1);
                    end
                end
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.init_perm  = init_perm;
    assign bus.perm_en    = adv;
    assign bus.last_round = perm_last;
    assign bus.done       = done;
    assign bus.step_cnt   = step_q;
    assign bus.round_cnt  = round_q;
    assign bus.rc         = rc_q;
    assign bus.sc         = sc_q;
endmodule

// File: tb/tb_spoc_perm_sched.sv
// Scoreboard bench: each accepted start pushes the expected round-cycle sequence and done cycle.
module tb_spoc_perm_sched;
    localparam int N   = 18;
    localparam int R   = 6;
    localparam int SW  = $clog2(N);
    localparam int RW  = $clog2(R);
    localparam int LAT = 2 + N * R;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spoc_perm_sched_if #(.NUM_STEPS(N), .ROUNDS_PER_STEP(R)) bus();

    spoc_perm_sched #(
        .NUM_STEPS(N), .ROUNDS_PER_STEP(R), .RC_SEED(6'h07), .SC_SEED(6'h2A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;

    // {last_round, step, round, rc, sc}
    logic [SW+RW+12:0] seq_q[$];
    int                done_q[$];
    logic [SW+RW+12:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [5:0] lfsr6(input logic [5:0] q);
        return {q[4:0], q[5] ^ q[4]};
    endfunction

    task automatic push_run();
        logic [5:0] rcv, scv;
        rcv = 6'h07;
        scv = 6'h2A;
        for (int s = 0; s < N; s++) begin
            for (int r = 0; r < R; r++) begin
                seq_q.push_back({(s == N-1 && r == R-1), SW'(s), RW'(r), rcv, scv});
                rcv = lfsr6(rcv);
                if (r == R-1) scv = lfsr6(scv);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick(1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.perm_en === 1'b1) begin
                chk("perm_pending", 32'(seq_q.size() != 0), 1);
                if (seq_q.size() != 0) begin
                    mon_exp = seq_q.pop_front();
                    chk("perm_seq", 32'({bus.last_round, bus.step_cnt, bus.round_cnt, bus.rc, bus.sc}),
                        32'(mon_exp));
                end
            end else begin
                chk("last_no_pen", 32'(bus.last_round), 0);
            end
            if (bus.done === 1'b1) begin
                chk("done_pending", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) chk("done_cyc", cyc, done_q.pop_front());
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_init"}, 32'(bus.init_perm), 0);
        chk({tag, "_pen"}, 32'(bus.perm_en), 0);
        chk({tag, "_last"}, 32'(bus.last_round), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_step"}, 32'(bus.step_cnt), 0);
        chk({tag, "_round"}, 32'(bus.round_cnt), 0);
        chk({tag, "_rc"}, 32'(bus.rc), 32'h07);
        chk({tag, "_sc"}, 32'(bus.sc), 32'h2A);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_seq_left"}, seq_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int c, c2;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        tick(3);
        @(negedge clk);
        chk_reset_vals("rst");
        tick(1);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // single run, no stall; constant values on early cycles
        c = cyc;
        bus.start = 1'b1;
        push_run();
        done_q.push_back(c + LAT);
        tick(1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("t1_init", 32'(bus.init_perm), 1);
        chk("t1_busy_load", 32'(bus.busy), 1);
        chk("t1_pen_load", 32'(bus.perm_en), 0);
        goto(c + 6);
        @(negedge clk);
        chk("t2_rc5", 32'(bus.rc), 32'h32);
        goto(c + 8);
        @(negedge clk);
        chk("t2_sc1", 32'(bus.sc), 32'h15);
        goto(c + LAT - 1);
        @(negedge clk);
        chk("t1_last", 32'(bus.last_round), 1);
        goto(c + LAT);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_busy_done", 32'(bus.busy), 0);
        goto(c + LAT + 3);
        chk_drained("t1");

        // 5 stall cycles in the middle of step 3
        c = cyc;
        bus.start = 1'b1;
        push_run();
        done_q.push_back(c + LAT + 5);
        tick(1);
        bus.start = 1'b0;
        goto(c + 22);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_pen", 32'(bus.perm_en), 0);
            chk("t3_hold", 32'({bus.step_cnt, bus.round_cnt, bus.rc, bus.sc}),
                32'(seq_q[0][SW+RW+11:0]));
            tick(1);
        end
        bus.stall = 1'b0;
        goto(c + LAT + 8);
        chk_drained("t3");

        // start re-pulsed in LOAD, RUN and DONE
        c = cyc;
        bus.start = 1'b1;
        push_run();
        done_q.push_back(c + LAT);
        tick(2);
        bus.start = 1'b0;
        goto(c + 40);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        goto(c + LAT);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        goto(c + LAT + 5);
        chk_drained("t4");

        // reset in RUN cycle 50
        c = cyc;
        bus.start = 1'b1;
        push_run();
        done_q.push_back(c + LAT);
        tick(1);
        bus.start = 1'b0;
        goto(c + 51);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        seq_q.delete();
        done_q.delete();
        @(negedge clk);
        chk_reset_vals("t5");
        goto(c + 60);
        c2 = cyc;
        bus.start = 1'b1;
        push_run();
        done_q.push_back(c2 + LAT);
        tick(1);
        bus.start = 1'b0;
        goto(c2 + LAT + 3);
        chk_drained("t5");

        // start held high: back-to-back runs
        c = cyc;
        bus.start = 1'b1;
        push_run();
        push_run();
        done_q.push_back(c + LAT);
        done_q.push_back(c + 2 * LAT + 1);
        goto(c + LAT + 2);
        @(negedge clk);
        chk("t6_reload", 32'(bus.init_perm), 1);
        goto(c + LAT + 5);
        bus.start = 1'b0;
        goto(c + 2 * LAT + 4);
        chk_drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
